// File: rtl/xor_gate_env_pkg.sv
// Shared types and response codes for the XOR-gate environment.
// Also holds the helper that classifies a gate output event against the tracked level.
package xor_gate_env_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_A = 3'd1,
        WAIT_A  = 3'd2,
        ISSUE_B = 3'd3,
        WAIT_B  = 3'd4,
        RSP     = 3'd5
    } env_state_e;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_GOOD = 2'd1,
        EV_BAD  = 2'd2
    } ev_kind_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;
    localparam logic [1:0] RSP_POL     = 2'b10;
    localparam logic [1:0] RSP_SPUR    = 2'b11;

    // The expected event moves the output away from its current level; anything else is wrong.
    function automatic ev_kind_e classify_event(input logic ev_p, input logic ev_m, input logic level);
        if (!ev_p && !ev_m) begin
            return EV_NONE;
        end
        if (ev_p && ev_m) begin
            return EV_BAD;
        end
        return (ev_p != level) ? EV_GOOD : EV_BAD;
    endfunction

    function automatic logic [1:0] ok_code(input logic spur_seen);
        return spur_seen ? RSP_SPUR : RSP_OK;
    endfunction

endpackage

// File: rtl/xor_gate_env_timer.sv
// Clear/enable cycle counter for the environment's response timeout.
// hit marks the TIMEOUT-th enabled cycle since the last clear.
module xor_gate_env_timer #(
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The cycle where the count reads TIMEOUT-1 is the TIMEOUT-th cycle spent waiting.
    assign hit = en && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !hit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/xor_gate_env_mealy.sv
// Initiator-side environment for the XOR-gate Mealy controller: turns level commands into
// single input pulses and checks each returned output event against a^b.
module xor_gate_env_mealy
    import xor_gate_env_pkg::*;
#(
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_a,
    input  logic       cmd_b,
    output logic       a_P,
    output logic       a_M,
    output logic       b_P,
    output logic       b_M,
    input  logic       out_P,
    input  logic       out_M,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_code,
    output logic       cur_a,
    output logic       cur_b,
    output logic       cur_out
);

    env_state_e state_q, state_d;
    logic       cmd_a_q, cmd_a_d;
    logic       cmd_b_q, cmd_b_d;
    logic       cur_a_q, cur_a_d;
    logic       cur_b_q, cur_b_d;
    logic       cur_out_q, cur_out_d;
    logic       a_p_q, a_p_d;
    logic       a_m_q, a_m_d;
    logic       b_p_q, b_p_d;
    logic       b_m_q, b_m_d;
    logic [1:0] rsp_code_q, rsp_code_d;
    logic       spur_q, spur_d;

    logic       in_flight;
    logic       a_side;
    logic       any_ev;
    logic       spur_now;
    logic       b_change;
    logic       timer_clr;
    logic       timer_hit;
    ev_kind_e   ev;

    assign in_flight = state_q inside {ISSUE_A, WAIT_A, ISSUE_B, WAIT_B};
    assign a_side    = state_q inside {ISSUE_A, WAIT_A};
    assign any_ev    = out_P | out_M;
    assign spur_now  = spur_q | (!in_flight && any_ev);
    assign b_change  = cmd_b_q != cur_b_q;
    assign ev        = classify_event(out_P, out_M, cur_out_q);

    xor_gate_env_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (in_flight),
        .hit   (timer_hit)
    );

    always_comb begin
        state_d    = state_q;
        cmd_a_d    = cmd_a_q;
        cmd_b_d    = cmd_b_q;
        cur_a_d    = cur_a_q;
        cur_b_d    = cur_b_q;
        cur_out_d  = cur_out_q;
        a_p_d      = 1'b0;
        a_m_d      = 1'b0;
        b_p_d      = 1'b0;
        b_m_d      = 1'b0;
        rsp_code_d = rsp_code_q;
        spur_d     = spur_now;
        timer_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_a_d = cmd_a;
                    cmd_b_d = cmd_b;
                    if (cmd_a != cur_a_q) begin
                        state_d   = ISSUE_A;
                        a_p_d     = cmd_a;
                        a_m_d     = !cmd_a;
                        timer_clr = 1'b1;
                    end else if (cmd_b != cur_b_q) begin
                        state_d   = ISSUE_B;
                        b_p_d     = cmd_b;
                        b_m_d     = !cmd_b;
                        timer_clr = 1'b1;
                    end else begin
                        state_d    = RSP;
                        rsp_code_d = ok_code(spur_now);
                    end
                end
            end

            ISSUE_A, WAIT_A, ISSUE_B, WAIT_B: begin
                if (state_q == ISSUE_A) begin
                    cur_a_d = cmd_a_q;
                end
                if (state_q == ISSUE_B) begin
                    cur_b_d = cmd_b_q;
                end
                state_d = a_side ? WAIT_A : WAIT_B;

                // A Mealy gate may answer within the ISSUE cycle, so events are honoured there too.
                if (ev == EV_GOOD) begin
                    cur_out_d = !cur_out_q;
                    if (a_side && b_change) begin
                        state_d   = ISSUE_B;
                        b_p_d     = cmd_b_q;
                        b_m_d     = !cmd_b_q;
                        timer_clr = 1'b1;
                    end else begin
                        state_d    = RSP;
                        rsp_code_d = ok_code(spur_now);
                    end
                end else if (ev == EV_BAD) begin
                    state_d    = RSP;
                    rsp_code_d = RSP_POL;
                end else if (timer_hit) begin
                    state_d    = RSP;
                    rsp_code_d = RSP_TIMEOUT;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    // Only the response that reported the stray event clears the flag.
                    if (rsp_code_q == RSP_SPUR) begin
                        spur_d = any_ev;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cmd_a_q    <= 1'b0;
            cmd_b_q    <= 1'b0;
            cur_a_q    <= 1'b0;
            cur_b_q    <= 1'b0;
            cur_out_q  <= 1'b0;
            a_p_q      <= 1'b0;
            a_m_q      <= 1'b0;
            b_p_q      <= 1'b0;
            b_m_q      <= 1'b0;
            rsp_code_q <= RSP_OK;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_a_q    <= cmd_a_d;
            cmd_b_q    <= cmd_b_d;
            cur_a_q    <= cur_a_d;
            cur_b_q    <= cur_b_d;
            cur_out_q  <= cur_out_d;
            a_p_q      <= a_p_d;
            a_m_q      <= a_m_d;
            b_p_q      <= b_p_d;
            b_m_q      <= b_m_d;
            rsp_code_q <= rsp_code_d;
            spur_q     <= spur_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_code  = rsp_code_q;
    assign a_P       = a_p_q;
    assign a_M       = a_m_q;
    assign b_P       = b_p_q;
    assign b_M       = b_m_q;
    assign cur_a     = cur_a_q;
    assign cur_b     = cur_b_q;
    assign cur_out   = cur_out_q;

endmodule
